// File: rtl/io_pkg.sv
// +----------------------------------------------------------------------+
// | io_pkg : shared constants and types for the LED/switch IO block       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package io_pkg;

  localparam logic [7:0] C_LED_ADDR  = 8'h60;
  localparam logic [7:0] C_SW_ADDR   = 8'h70;
  localparam logic [7:0] C_STAT_ADDR = 8'h78;

  typedef logic [15:0] io_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

endpackage : io_pkg

`default_nettype wire

// File: rtl/sw_debounce.sv
// +----------------------------------------------------------------------+
// | sw_debounce : 2-flop switch synchronizer plus optional debounce FSM   |
// | Optional feature macro: SWITCH_DEBOUNCE_EN                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sw_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw_raw,
  output logic [15:0] sw_db,
  output logic        db_changed
);

  io_word_t r_sync1;
  io_word_t r_sync2;
  io_word_t r_sw_db;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_cfg_check
    $error("sw_debounce: DEBOUNCE_CYCLES out of range 2..2^20");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign sw_db = r_sw_db;

`ifdef SWITCH_DEBOUNCE_EN

  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        r_state;
  db_state_t        w_state_nxt;
  io_word_t         r_sw_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_capture;
  logic             w_cnt_en;
  logic             w_load;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_sync2 != r_sw_db) w_state_nxt = COUNT;
      end
      COUNT: begin
        if (r_sync2 == r_sw_cand) begin
          if (w_cnt_inc == C_CNT_LAST) w_state_nxt = IDLE;
        end else if (r_sync2 == r_sw_db) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Load fires on the edge the incremented count reaches the last value,
  // so the counter itself never holds more than DEBOUNCE_CYCLES-2.
  always_comb begin
    w_capture = 1'b0;
    w_cnt_en  = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2 != r_sw_db) w_capture = 1'b1;
      end
      COUNT: begin
        if (r_sync2 == r_sw_cand) begin
          if (w_cnt_inc == C_CNT_LAST) w_load   = 1'b1;
          else                         w_cnt_en = 1'b1;
        end else if (r_sync2 != r_sw_db) begin
          w_capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_cand <= '0;
      r_cnt     <= '0;
      r_sw_db   <= '0;
    end else begin
      if (w_capture) begin
        r_sw_cand <= r_sync2;
        r_cnt     <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_load) r_sw_db <= r_sw_cand;
    end
  end

  assign db_changed = w_load && (r_sw_cand != r_sw_db);

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_db <= '0;
    end else begin
      r_sw_db <= r_sync2;
    end
  end

  assign db_changed = (r_sync2 != r_sw_db);

`endif

endmodule : sw_debounce

`default_nettype wire

// File: rtl/led_switch_io.sv
// +----------------------------------------------------------------------+
// | led_switch_io : memory-mapped LED register, switch input and status   |
// | Optional feature macro: SWITCH_DEBOUNCE_EN (passed to sw_debounce)    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module led_switch_io
  import io_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 20000,
  parameter logic [7:0] LED_ADDR        = C_LED_ADDR,
  parameter logic [7:0] SW_ADDR         = C_SW_ADDR,
  parameter logic [7:0] STAT_ADDR       = C_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic [7:0]  addr,
  input  logic [31:0] write_data,
  input  logic [15:0] sw_raw,
  output logic [15:0] led,
  output logic [15:0] io_rdata
);

  io_word_t r_led;
  io_word_t w_sw_db;
  logic     r_chg;
  logic     w_chg_set;
  logic     w_chg_clr;
  logic     w_led_wr;
  logic     w_rd_sel;
  logic     w_unused_wdata;

  assign w_unused_wdata = ^write_data[31:16];

  sw_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .sw_db      (w_sw_db),
    .db_changed (w_chg_set)
  );

  assign w_led_wr  = LEDCtrl && ioWrite && (addr == LED_ADDR);
  assign w_rd_sel  = SwitchCtrl && ioRead;
  assign w_chg_clr = w_rd_sel && (addr == STAT_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else if (w_led_wr) begin
      r_led <= write_data[15:0];
    end
  end

  // A fresh change on the clearing edge must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg <= 1'b0;
    end else if (w_chg_set) begin
      r_chg <= 1'b1;
    end else if (w_chg_clr) begin
      r_chg <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (w_rd_sel) begin
      case (addr)
        SW_ADDR:   io_rdata = w_sw_db;
        STAT_ADDR: io_rdata = {15'b0, r_chg};
        LED_ADDR:  io_rdata = r_led;
        default:   io_rdata = '0;
      endcase
    end
  end

  assign led = r_led;

endmodule : led_switch_io

`default_nettype wire
